bit_serializer: RTL

Upstream feeder for the serial sequence detector: accepts parallel words over a valid/ready handshake and emits them one bit per clock on `sout`, which drives the detector's `x` input. A one-entry holding register lets the next word queue during shifting, so consecutive words stream with no gap bits. When no word is queued the block drives `sout = 0`.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/ser_hold_reg.sv | 44 ++++
 rtl/bit_serializer.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector.
package seq_pkg;

  localparam int SEQ_W = 8;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Detector states: DET_A..DET_E track progress through the target pattern
  typedef enum logic [2:0] {
    DET_IDLE = 3'd0,
    DET_A    = 3'd1,
    DET_B    = 3'd2,
    DET_C    = 3'd3,
    DET_D    = 3'd4,
    DET_E    = 3'd5
  } det_state_e;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register between the word source and the shifter.
module ser_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         take_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         ready_o
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  assign ready_o = rst && !full_q;
  assign data_o  = data_q;
  assign full_o  = full_q;

  // take and an accepted load are exclusive: ready is low whenever full is set
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (take_i) begin
      full_d = 1'b0;
    end else if (load_i && ready_o) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector; words queue in a
// one-entry hold register so consecutive words stream without gap bits.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   SER_IDLE  | no word shifting; sout = 0; loads shifter when hold is full
//   SER_SHIFT | sout carries a data bit; cnt = bits still to follow
module bit_serializer
  import seq_pkg::*;
#(
  parameter int W         = SEQ_W,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 sout,
  output logic                 sout_valid,
  output logic                 last,
  output logic [$clog2(W)-1:0] bit_idx
);

  localparam int CW = $clog2(W);

  ser_state_e    state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  hold_data;
  logic          hold_full;
  logic          take;

  ser_hold_reg #(.W(W)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (din_valid),
    .take_i  (take),
    .data_i  (din),
    .data_o  (hold_data),
    .full_o  (hold_full),
    .ready_o (din_ready)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (hold_full) begin
          sr_d    = hold_data;
          cnt_d   = CW'(W - 1);
          take    = 1'b1;
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (cnt_q != '0) begin
          if (MSB_FIRST != 0) sr_d = {sr_q[W-2:0], 1'b0};
          else                sr_d = {1'b0, sr_q[W-1:1]};
          cnt_d = cnt_q - 1'b1;
        end else if (hold_full) begin
          // reload on the final bit so the next word follows with no bubble
          sr_d  = hold_data;
          cnt_d = CW'(W - 1);
          take  = 1'b1;
        end else begin
          state_d = SER_IDLE;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SER_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sout_valid = (state_q == SER_SHIFT);
  assign sout       = sout_valid && ((MSB_FIRST != 0) ? sr_q[W-1] : sr_q[0]);
  assign last       = sout_valid && (cnt_q == '0);
  assign bit_idx    = sout_valid ? cnt_q : '0;

endmodule
